gearbox_meter: RTL and testbench
================================

GEARBOX_METER -- requirements
Module: gearbox_meter

Interface
REQ-001 SHALL have parameter DW, default 8: width of the measured ratio word, matching the gearbox enable generator it observes.
REQ-002 SHALL have parameter AVG, default 0: the window is 2**(DW+AVG) cycles; the result is averaged over 2**AVG gearbox periods.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: a one-cycle request to begin a measurement.
REQ-006 SHALL have port clr, input, 1: synchronous abort.
REQ-007 SHALL have port cont, input, 1: continuous mode; windows repeat back-to-back while high.
REQ-008 SHALL have port gen_in, input, 1: the gated-enable pulse stream under test, synchronous to clk.
REQ-009 SHALL have port busy, output, 1: high while in MEASURE.
REQ-010 SHALL have port valid, output, 1: one-cycle pulse that marks a new result.
REQ-011 SHALL have port gnum_out, output, DW: the recovered ratio word, held between results.
REQ-012 SHALL have port zero, output, 1: high when the last window contained no pulses; held with gnum_out.

Function
REQ-013 SHALL implement FSM states IDLE and MEASURE.
- IDLE -> MEASURE on start.
- MEASURE -> IDLE at window end when cont=0.
- MEASURE -> MEASURE at window end when cont=1.
REQ-014 SHALL clear the window counter (DW+AVG bits) and the pulse counter (DW+AVG+1 bits) on the edge that enters MEASURE.
REQ-015 SHALL, in MEASURE, increment the window counter every cycle and increment the pulse counter on each cycle gen_in=1.
- The window is exactly 2**(DW+AVG) consecutive gen_in samples.
- The first sample is taken on the edge after start is sampled.
REQ-016 SHALL recognise window end when the window counter equals all-ones and the last sample has been taken.
REQ-017 SHALL compute the total as P, the pulse count including the final sample.
REQ-018 SHALL, for P>0, set gnum_out = (P >> AVG) - 1, truncated to DW bits, with zero=0.
REQ-019 SHALL, for P=0, set gnum_out = 0 and zero=1.
REQ-020 SHALL update gnum_out and zero, and assert valid, registered on the edge following the last window sample: valid is high for exactly one cycle.
REQ-021 SHALL, in continuous mode, start the next window with no gap on the same edge that asserts valid; counters restart from 0 plus that edge's sample.
- Result: one valid every 2**(DW+AVG) cycles.
REQ-022 SHALL ignore start while in MEASURE.
REQ-023 SHALL, on clr, force IDLE on the next edge, zero both counters and suppress valid; gnum_out and zero keep their previous values.
REQ-024 SHALL give clr priority over start in the same cycle, and over a coincident window end (no valid).
REQ-025 SHALL, when cont falls mid-window, complete the current window, report it, then go to IDLE.
REQ-026 SHALL not saturate or wrap the pulse counter: a gen_in stuck high gives P = 2**(DW+AVG), so gnum_out = 2**DW-1.
REQ-027 SHALL recover the exact gnum for any phase alignment of a constant-ratio gearbox stream: a gearbox with gnum=N>0 yields N+1 pulses per 2**DW cycles.

Reset
REQ-028 SHALL, on reset assertion, asynchronously force: state=IDLE, both counters=0, busy=0, valid=0, gnum_out=0, zero=0.
REQ-029 SHALL leave reset deassertion without side effects; a measurement starts only on a subsequent start.

Configuration
REQ-030 SHALL, with macro GEARBOX_METER_CMP_EN defined, add:
- input gnum_exp[DW-1:0]
- output mismatch (1 bit), registered with valid, = (gnum_out_new != gnum_exp) OR zero_new, held until the next result or reset (reset value 0).
REQ-031 SHALL, with GEARBOX_METER_CMP_EN undefined, omit gnum_exp and mismatch entirely; all other behaviour is unchanged.

Verification (DW=4, AVG=0, 16-cycle window unless stated)
REQ-032 SHALL cover: gen_in held 1, start pulse -> busy for 16 cycles, valid once, gnum_out=15, zero=0.
REQ-033 SHALL cover: gen_in from a gearbox with gnum=5, start at three different phase offsets -> gnum_out=5 each time.
REQ-034 SHALL cover: gen_in held 0 -> gnum_out=0, zero=1; then gearbox gnum=0 -> gnum_out=0, zero=1.
REQ-035 SHALL cover: cont=1, gearbox gnum=9 -> valid every 16 cycles with no gap, gnum_out=9; drop cont mid-window -> one more valid, then busy=0.
REQ-036 SHALL cover: clr at window cycle 8; clr coincident with start; clr at window end -> no valid, busy=0 next cycle, gnum_out keeps its previous value; async reset mid-window -> all outputs 0 immediately.
REQ-037 SHALL cover, with GEARBOX_METER_CMP_EN defined, AVG=2: gearbox gnum=3, gnum_exp=3 -> mismatch=0; gnum_exp=4 -> mismatch=1, at 64-cycle valid spacing.

Source files
------------

// File: rtl/gearbox_meter.sv
// Measures the ratio word of a gated-enable stream by counting pulses over 2**(DW+AVG) cycles.
// Optional expected-value comparator enabled by defining GEARBOX_METER_CMP_EN.
// state   | meaning
// IDLE    | waiting for start; result registers hold the last measurement
// MEASURE | counting window cycles and gen_in pulses
module gearbox_meter #(
   parameter int DW  = 8,
   parameter int AVG = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          clr,
   input  logic          cont,
   input  logic          gen_in,
`ifdef GEARBOX_METER_CMP_EN
   input  logic [DW-1:0] gnum_exp,
   output logic          mismatch,
`endif
   output logic          busy,
   output logic          valid,
   output logic [DW-1:0] gnum_out,
   output logic          zero
);

   localparam int CW = DW + AVG;

   typedef enum logic {S_IDLE, S_MEASURE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] win_q, win_d;
   logic [CW:0]   pul_q, pul_d;
   logic          valid_q, valid_d;
   logic [DW-1:0] gnum_q, gnum_d;
   logic          zero_q, zero_d;
   logic          win_end;
   logic [CW:0]   p_total;
   logic [CW:0]   p_shift;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         win_q   <= '0;
         pul_q   <= '0;
         valid_q <= 1'b0;
         gnum_q  <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         pul_q   <= pul_d;
         valid_q <= valid_d;
         gnum_q  <= gnum_d;
         zero_q  <= zero_d;
      end
   end

   // The pulse counter is one bit wider than the window so a stuck-high input cannot wrap.
   always_comb begin
      p_total = pul_q + {{CW{1'b0}}, gen_in};
      p_shift = p_total >> AVG;
      win_end = (state_q == S_MEASURE) && (win_q == '1);
      state_d = state_q;
      win_d   = win_q;
      pul_d   = pul_q;
      valid_d = 1'b0;
      gnum_d  = gnum_q;
      zero_d  = zero_q;
      if (clr) begin
         state_d = S_IDLE;
         win_d   = '0;
         pul_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_MEASURE;
                  win_d   = '0;
                  pul_d   = '0;
               end
            end
            S_MEASURE: begin
               win_d = win_q + 1'b1;
               pul_d = p_total;
               if (win_end) begin
                  valid_d = 1'b1;
                  win_d   = '0;
                  pul_d   = '0;
                  if (!cont) state_d = S_IDLE;
                  if (p_total == '0) begin
                     gnum_d = '0;
                     zero_d = 1'b1;
                  end else begin
                     gnum_d = p_shift[DW-1:0] - 1'b1;
                     zero_d = 1'b0;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign busy     = (state_q == S_MEASURE);
   assign valid    = valid_q;
   assign gnum_out = gnum_q;
   assign zero     = zero_q;

`ifdef GEARBOX_METER_CMP_EN
   logic mismatch_q, mismatch_d;

   always_comb begin
      mismatch_d = mismatch_q;
      if (valid_d) mismatch_d = (gnum_d != gnum_exp) || zero_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) mismatch_q <= 1'b0;
      else       mismatch_q <= mismatch_d;
   end

   assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_gearbox_meter.sv
// Bench for gearbox_meter (DW=4, AVG=0); a second AVG=2 instance is checked when
// GEARBOX_METER_CMP_EN is defined.
module tb_gearbox_meter;
   localparam int DW = 4;
   localparam int N  = 16;

   logic       clk = 1'b0;
   logic       reset, start, clr, cont, gen_in;
   logic       busy, valid, zero;
   logic [3:0] gnum_out;

   int n_cmp = 0;
   int n_err = 0;

   int src_mode = 0;
   int gb_n     = 0;
   int gb_acc   = 0;
   int last_g   = 0;
   int last_z   = 0;

`ifdef GEARBOX_METER_CMP_EN
   logic       start2, busy2, valid2, zero2, mismatch2, mm_unused;
   logic [3:0] gnum2, gnum_exp2;
`endif

   gearbox_meter #(.DW(DW), .AVG(0)) dut (
      .clk(clk), .reset(reset), .start(start), .clr(clr), .cont(cont), .gen_in(gen_in),
`ifdef GEARBOX_METER_CMP_EN
      .gnum_exp(4'd0), .mismatch(mm_unused),
`endif
      .busy(busy), .valid(valid), .gnum_out(gnum_out), .zero(zero)
   );

`ifdef GEARBOX_METER_CMP_EN
   gearbox_meter #(.DW(DW), .AVG(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .clr(clr), .cont(cont), .gen_in(gen_in),
      .gnum_exp(gnum_exp2), .mismatch(mismatch2),
      .busy(busy2), .valid(valid2), .gnum_out(gnum2), .zero(zero2)
   );
`endif

   always #5 clk = ~clk;

   // Ratio word implied by a pulse count over 2**(DW+avg) samples.
   function automatic int model_gnum(input int p, input int avg);
      if (p == 0) return 0;
      return ((p >> avg) - 1) % (1 << DW);
   endfunction

   // Next gen_in value: constant, an ideal gearbox of ratio gb_n, or random.
   task automatic drive_gen();
      case (src_mode)
         0: gen_in = 1'b0;
         1: gen_in = 1'b1;
         2: begin
            gen_in = 1'b0;
            if (gb_n != 0) begin
               gb_acc += gb_n + 1;
               if (gb_acc >= N) begin
                  gb_acc -= N;
                  gen_in = 1'b1;
               end
            end
         end
         default: gen_in = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_single(input string tag, input int idle_cyc, input bit use_want,
                             input int want_g, input int want_z);
      int p, bad, eg, ez;
      for (int i = 0; i < idle_cyc; i++) begin
         drive_gen();
         step();
      end
      start = 1'b1;
      drive_gen();
      step();
      start = 1'b0;
      p = 0;
      bad = 0;
      for (int i = 0; i < N; i++) begin
         if (busy !== 1'b1 || valid !== 1'b0) bad++;
         drive_gen();
         p += int'(gen_in);
         step();
      end
      eg = model_gnum(p, 0);
      ez = (p == 0) ? 1 : 0;
      n_cmp++;
      if (bad !== 0) begin n_err++; $display("FAIL %s busy_window: bad cycles %0d, want 0", tag, bad); end
      n_cmp++;
      if (valid !== 1'b1) begin n_err++; $display("FAIL %s valid: got %b want 1", tag, valid); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_end: got %b want 0", tag, busy); end
      n_cmp++;
      if (gnum_out !== 4'(eg)) begin n_err++; $display("FAIL %s gnum: got %0d want %0d", tag, gnum_out, eg); end
      n_cmp++;
      if (zero !== 1'(ez)) begin n_err++; $display("FAIL %s zero: got %b want %0d", tag, zero, ez); end
      if (use_want) begin
         n_cmp++;
         if (gnum_out !== 4'(want_g) || zero !== 1'(want_z)) begin
            n_err++;
            $display("FAIL %s ratio: got %0d/%b want %0d/%0d", tag, gnum_out, zero, want_g, want_z);
         end
      end
      last_g = eg;
      last_z = ez;
      drive_gen();
      step();
      n_cmp++;
      if (valid !== 1'b0) begin n_err++; $display("FAIL %s valid_pulse: got %b want 0", tag, valid); end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; clr = 1'b0; cont = 1'b0; gen_in = 1'b0;
      repeat (2) step();
      n_cmp++;
      if ({busy, valid, zero, gnum_out} !== 7'd0) begin
         n_err++;
         $display("FAIL reset_state: got busy%b valid%b zero%b gnum%0d want all 0", busy, valid, zero, gnum_out);
      end
      reset = 1'b0;
      repeat (3) step();
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_release: busy %b want 0", busy); end
   endtask

   task automatic test_single();
      src_mode = 1;
      run_single("stuck_high", 2, 1, 15, 0);
      src_mode = 2; gb_n = 5;
      for (int k = 0; k < 3; k++) run_single("gb5_phase", 3 + 5 * k, 1, 5, 0);
      src_mode = 0;
      run_single("stuck_low", 1, 1, 0, 1);
      src_mode = 2; gb_n = 0;
      run_single("gb0", 4, 1, 0, 1);
      src_mode = 3;
      for (int k = 0; k < 6; k++) run_single("random", int'($urandom_range(0, 7)), 0, 0, 0);
      src_mode = 2;
      for (int k = 0; k < 4; k++) begin
         gb_n = int'($urandom_range(1, 15));
         run_single("gb_rand", int'($urandom_range(0, 15)), 1, gb_n, 0);
      end
   endtask

   task automatic test_back_to_back();
      int p, eg, gap_bad;
      src_mode = 2; gb_n = 9;
      cont = 1'b1;
      start = 1'b1;
      drive_gen();
      step();
      start = 1'b0;
      p = 0;
      gap_bad = 0;
      for (int c = 0; c < 4 * N; c++) begin
         if (c == 3 * N + 5) cont = 1'b0;
         drive_gen();
         p += int'(gen_in);
         step();
         if ((c + 1) % N == 0) begin
            eg = model_gnum(p, 0);
            p = 0;
            n_cmp++;
            if (valid !== 1'b1 || gnum_out !== 4'(eg) || gnum_out !== 4'd9) begin
               n_err++;
               $display("FAIL cont_window%0d: valid %b gnum %0d want 1/%0d", c / N, valid, gnum_out, eg);
            end
            n_cmp++;
            if (busy !== ((c + 1 < 4 * N) ? 1'b1 : 1'b0)) begin
               n_err++;
               $display("FAIL cont_busy%0d: got %b", c / N, busy);
            end
            last_g = eg;
            last_z = 0;
         end else if (valid !== 1'b0) gap_bad++;
      end
      n_cmp++;
      if (gap_bad !== 0) begin n_err++; $display("FAIL cont_spacing: %0d stray valids want 0", gap_bad); end
      repeat (N + 2) begin
         drive_gen();
         step();
         if (valid !== 1'b0 || busy !== 1'b0) gap_bad++;
      end
      n_cmp++;
      if (gap_bad !== 0) begin n_err++; $display("FAIL cont_stop: %0d active cycles want 0", gap_bad); end
   endtask

   task automatic clr_after(input string tag, input int at_cycle, input bit with_start);
      int bad;
      bad = 0;
      start = 1'b1;
      if (with_start) clr = 1'b1;
      drive_gen();
      step();
      start = 1'b0;
      for (int i = 0; i < at_cycle && !with_start; i++) begin
         drive_gen();
         step();
      end
      if (!with_start) clr = 1'b1;
      drive_gen();
      step();
      clr = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s after_clr: busy %b valid %b want 0/0", tag, busy, valid);
      end
      for (int i = 0; i < N + 2; i++) begin
         drive_gen();
         step();
         if (valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin n_err++; $display("FAIL %s quiet: %0d active cycles want 0", tag, bad); end
      n_cmp++;
      if (gnum_out !== 4'(last_g) || zero !== 1'(last_z)) begin
         n_err++;
         $display("FAIL %s hold: got %0d/%b want %0d/%0d", tag, gnum_out, zero, last_g, last_z);
      end
   endtask

   task automatic test_clr();
      src_mode = 2; gb_n = 5;
      run_single("pre_clr", 1, 1, 5, 0);
      clr_after("clr_mid", 7, 0);
      clr_after("clr_start", 0, 1);
      clr_after("clr_end", N - 1, 0);
   endtask

   task automatic test_async_reset();
      int bad;
      src_mode = 1;
      run_single("pre_reset", 0, 1, 15, 0);
      start = 1'b1;
      drive_gen();
      step();
      start = 1'b0;
      repeat (6) begin drive_gen(); step(); end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({busy, valid, zero, gnum_out} !== 7'd0) begin
         n_err++;
         $display("FAIL async_reset: busy%b valid%b zero%b gnum%0d want all 0", busy, valid, zero, gnum_out);
      end
      step();
      reset = 1'b0;
      last_g = 0; last_z = 0;
      bad = 0;
      repeat (N + 4) begin
         drive_gen();
         step();
         if (busy !== 1'b0 || valid !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin n_err++; $display("FAIL reset_quiet: %0d active cycles want 0", bad); end
   endtask

`ifdef GEARBOX_METER_CMP_EN
   task automatic test_cmp();
      int p, eg, em;
      src_mode = 2; gb_n = 3;
      gnum_exp2 = 4'd3;
      cont = 1'b1;
      start2 = 1'b1;
      drive_gen();
      step();
      start2 = 1'b0;
      p = 0;
      for (int c = 0; c < 2 * 4 * N; c++) begin
         if (c == 4 * N) gnum_exp2 = 4'd4;
         if (c == 4 * N + 10) cont = 1'b0;
         drive_gen();
         p += int'(gen_in);
         step();
         if ((c + 1) % (4 * N) == 0) begin
            eg = model_gnum(p, 2);
            em = (eg != int'(gnum_exp2) || p == 0) ? 1 : 0;
            p = 0;
            n_cmp++;
            if (valid2 !== 1'b1 || gnum2 !== 4'(eg) || mismatch2 !== 1'(em)) begin
               n_err++;
               $display("FAIL cmp_window%0d: valid %b gnum %0d mismatch %b want 1/%0d/%0d",
                        c / (4 * N), valid2, gnum2, mismatch2, eg, em);
            end
         end
      end
      n_cmp++;
      if (busy2 !== 1'b0) begin n_err++; $display("FAIL cmp_stop: busy %b want 0", busy2); end
   endtask
`endif

   initial begin
`ifdef GEARBOX_METER_CMP_EN
      start2 = 1'b0;
      gnum_exp2 = 4'd0;
`endif
      test_reset();
      test_single();
      test_back_to_back();
      test_clr();
      test_async_reset();
`ifdef GEARBOX_METER_CMP_EN
      test_cmp();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
